// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//
// Walks the systolic array's row/column selects over every PE in row-major
// order once a matrix product is complete. Each selected result is
// registered and presented as one word of a val/rdy stream.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start_val / start_rdy    drain request handshake (rdy only while idle)
//   out_rsel / out_csel      row/column select driven into the array
//   b_s_out                  selected PE result (combinational from selects)
//   send_msg / send_val /
//   send_rdy / send_last     result stream; last flags element (size-1,size-1)
//   busy                     drain in progress
//   done                     one-cycle pulse after the final word is taken
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_val; start_rdy high
// LOAD  | selects settling; b_s_out captured into send_msg at the edge
// SEND  | send_val high; word held until send_rdy
// DONE  | one-cycle done pulse, then back to IDLE

module systolic_result_drain #(
  parameter int size  = 16,
  parameter int nbits = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_val,
  output logic                    start_rdy,
  output logic [$clog2(size)-1:0] out_rsel,
  output logic [$clog2(size)-1:0] out_csel,
  input  logic [nbits-1:0]        b_s_out,
  output logic [nbits-1:0]        send_msg,
  output logic                    send_val,
  input  logic                    send_rdy,
  output logic                    send_last,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(size);
  // Counters wrap at this value rather than at 2^CW so that sizes which are
  // not a power of two never select a nonexistent row or column.
  localparam logic [CW-1:0] LAST_IDX = CW'(size - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;

  assign out_rsel  = row;
  assign out_csel  = col;
  assign start_rdy = (state == IDLE);
  assign busy      = (state == LOAD) || (state == SEND);
  assign send_val  = (state == SEND);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      send_msg  <= '0;
      send_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_val) begin
            row   <= '0;
            col   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          send_msg  <= b_s_out;
          send_last <= (row == LAST_IDX) && (col == LAST_IDX);
          state     <= SEND;
        end
        SEND: begin
          if (send_rdy) begin
            if (send_last) begin
              // Clear so the flag does not linger outside the final word.
              send_last <= 1'b0;
              state     <= DONE;
            end else begin
              if (col == LAST_IDX) begin
                col <= '0;
                row <= row + CW'(1);
              end else begin
                col <= col + CW'(1);
              end
              state <= LOAD;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // size=4 instance
  logic        start_val, start_rdy, send_val, send_rdy, send_last, busy, done;
  logic [1:0]  rsel, csel;
  logic [15:0] b_s_out, send_msg;
  assign b_s_out = {8'h00, 2'b00, rsel, 2'b00, csel};

  systolic_result_drain #(.size(4), .nbits(16)) dut4 (
    .clk(clk), .rst(rst),
    .start_val(start_val), .start_rdy(start_rdy),
    .out_rsel(rsel), .out_csel(csel),
    .b_s_out(b_s_out),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .send_last(send_last), .busy(busy), .done(done)
  );

  // size=3 instance
  logic        s3_start_val, s3_start_rdy, s3_send_val, s3_send_rdy, s3_send_last, s3_busy, s3_done;
  logic [1:0]  s3_rsel, s3_csel;
  logic [15:0] s3_b_s_out, s3_send_msg;
  assign s3_b_s_out = {8'h00, 2'b00, s3_rsel, 2'b00, s3_csel};

  systolic_result_drain #(.size(3), .nbits(16)) dut3 (
    .clk(clk), .rst(rst),
    .start_val(s3_start_val), .start_rdy(s3_start_rdy),
    .out_rsel(s3_rsel), .out_csel(s3_csel),
    .b_s_out(s3_b_s_out),
    .send_msg(s3_send_msg), .send_val(s3_send_val), .send_rdy(s3_send_rdy),
    .send_last(s3_send_last), .busy(s3_busy), .done(s3_done)
  );

  typedef struct packed {
    logic [15:0] msg;
    logic        last;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_done4 = 0;
  int n_done3 = 0;
  int max_sel3 = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_drain(input bit d3);
    int n;
    n = d3 ? 3 : 4;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        exp_t e;
        e.msg  = 16'(r * 16 + c);
        e.last = (r == n - 1) && (c == n - 1);
        if (d3) q3.push_back(e);
        else    q4.push_back(e);
      end
  endtask

  task automatic wait_done(input bit d3, input int base, output int cyc);
    cyc = base;
    do begin
      tick();
      cyc++;
    end while (!(d3 ? s3_done : done) && cyc < 400);
    if (cyc >= 400) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_word4(input logic [15:0] w);
    int k;
    k = 0;
    while (!(send_val && send_msg == w) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk("word_timeout", 32'(send_msg), 32'(w));
  endtask

  // Scoreboard monitors: pop on every accepted word.
  always @(negedge clk) begin
    if (rst && send_val && send_rdy) begin
      if (q4.size() == 0) begin
        chk("word4_unexpected", 32'(send_msg), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("word4_msg", 32'(send_msg), 32'(e.msg));
        chk("word4_last", 32'(send_last), 32'(e.last));
      end
    end
    if (rst && done) n_done4++;
  end

  always @(negedge clk) begin
    if (rst && s3_send_val && s3_send_rdy) begin
      if (q3.size() == 0) begin
        chk("word3_unexpected", 32'(s3_send_msg), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("word3_msg", 32'(s3_send_msg), 32'(e.msg));
        chk("word3_last", 32'(s3_send_last), 32'(e.last));
      end
    end
    if (rst && s3_done) n_done3++;
    if (int'(s3_rsel) > max_sel3) max_sel3 = int'(s3_rsel);
    if (int'(s3_csel) > max_sel3) max_sel3 = int'(s3_csel);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, c1, c2;
    rst = 1'b0;
    start_val = 1'b0; send_rdy = 1'b1;
    s3_start_val = 1'b0; s3_send_rdy = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_send_val", 32'(send_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_send_msg", 32'(send_msg), 32'd0);
    chk("rst_send_last", 32'(send_last), 32'd0);
    chk("rst_sel", 32'({rsel, csel}), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_start_rdy", 32'(start_rdy), 32'd1);

    // Full drain, rdy held high
    n_done4 = 0;
    push_drain(1'b0);
    start_val = 1'b1; tick(); start_val = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_send_val", 32'(send_val), 32'd0);
    chk("load_start_rdy", 32'(start_rdy), 32'd0);
    tick();
    chk("first_send_val", 32'(send_val), 32'd1);
    wait_done(1'b0, 1, cyc);
    chk("done_latency", 32'(cyc + 1), 32'd33);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_start_rdy", 32'(start_rdy), 32'd1);
    chk("full_q_empty", 32'(q4.size()), 32'd0);
    chk("full_done_count", 32'(n_done4), 32'd1);

    // Backpressure on word 0x11
    n_done4 = 0;
    push_drain(1'b0);
    start_val = 1'b1; tick(); start_val = 1'b0;
    begin
      int k;
      k = 0;
      while (!(busy && !send_val && rsel == 2'd1 && csel == 2'd1) && k < 200) begin
        tick();
        k++;
      end
      if (k >= 200) chk("bp_load_timeout", 32'd0, 32'd1);
    end
    send_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_send_val", 32'(send_val), 32'd1);
      chk("bp_send_msg", 32'(send_msg), 32'h11);
    end
    send_rdy = 1'b1;
    wait_done(1'b0, 0, cyc);
    tick();
    chk("bp_q_empty", 32'(q4.size()), 32'd0);
    chk("bp_done_count", 32'(n_done4), 32'd1);

    // Start pulse while busy
    n_done4 = 0;
    push_drain(1'b0);
    start_val = 1'b1; tick(); start_val = 1'b0;
    wait_word4(16'h02);
    start_val = 1'b1;
    chk("busy_start_rdy", 32'(start_rdy), 32'd0);
    tick();
    start_val = 1'b0;
    chk("busy_start_rdy2", 32'(start_rdy), 32'd0);
    wait_done(1'b0, 0, cyc);
    repeat (6) tick();
    chk("busy_done_count", 32'(n_done4), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("busy_q_empty", 32'(q4.size()), 32'd0);

    // Reset mid-drain while 0x13 is presented
    push_drain(1'b0);
    start_val = 1'b1; tick(); start_val = 1'b0;
    wait_word4(16'h13);
    rst = 1'b0;
    #1;
    chk("midrst_send_val", 32'(send_val), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sel", 32'({rsel, csel}), 32'd0);
    chk("midrst_send_msg", 32'(send_msg), 32'd0);
    q4.delete();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_start_rdy", 32'(start_rdy), 32'd1);
    n_done4 = 0;
    push_drain(1'b0);
    start_val = 1'b1; tick(); start_val = 1'b0;
    wait_done(1'b0, 0, cyc);
    chk("midrst_done_latency", 32'(cyc + 1), 32'd33);
    tick();
    chk("midrst_q_empty", 32'(q4.size()), 32'd0);

    // Back-to-back drains with start_val held
    n_done4 = 0;
    push_drain(1'b0);
    push_drain(1'b0);
    start_val = 1'b1;
    tick();
    wait_done(1'b0, 0, c1);
    chk("b2b_first_latency", 32'(c1 + 1), 32'd33);
    wait_done(1'b0, 0, c2);
    start_val = 1'b0;
    chk("b2b_done_gap", 32'(c2), 32'd34);
    repeat (5) tick();
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_done_count", 32'(n_done4), 32'd2);
    chk("b2b_q_empty", 32'(q4.size()), 32'd0);

    // size=3 drain
    push_drain(1'b1);
    s3_start_val = 1'b1; tick(); s3_start_val = 1'b0;
    wait_done(1'b1, 0, cyc);
    chk("s3_done_latency", 32'(cyc + 1), 32'd19);
    tick();
    chk("s3_q_empty", 32'(q3.size()), 32'd0);
    chk("s3_max_sel", 32'(max_sel3), 32'd2);
    chk("s3_done_count", 32'(n_done3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
